// File: rtl/board_state_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared definitions for the board state scanner. Contains the
//               tile encoding bit positions, winner codes and the scanner
//               FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

  // Each tile is a two-bit field: {occupied, colour}.
  localparam int   OCC_BIT   = 1;
  localparam int   COLOR_BIT = 0;
  localparam logic COLOR_RED = 1'b1;

  // Winner codes. Both flags set means the board cannot arise in legal play.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BLUE = 2'b01;
  localparam logic [1:0] WIN_RED  = 2'b10;
  localparam logic [1:0] WIN_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/board_state_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : board_state_scanner_if
// Description : Request/result bundle between game-state logic (master) and
//               the board state scanner (slave).
//               master drives : start, board_in
//               slave drives  : busy, done, red_pos, blue_pos, red_count,
//                               blue_count, winner, board_full
// Revision    : 1.0 - initial release
// ============================================================================
interface board_state_scanner_if #(
  parameter int SIDE = 3,
  parameter int CW   = $clog2(SIDE*SIDE+1)
);
  localparam int TILES = SIDE * SIDE;

  logic                 start;
  logic [2*TILES-1:0]   board_in;
  logic                 busy;
  logic                 done;
  logic [TILES-1:0]     red_pos;
  logic [TILES-1:0]     blue_pos;
  logic [CW-1:0]        red_count;
  logic [CW-1:0]        blue_count;
  logic [1:0]           winner;
  logic                 board_full;

  modport master (
    output start, board_in,
    input  busy, done, red_pos, blue_pos, red_count, blue_count,
           winner, board_full
  );

  modport slave (
    input  start, board_in,
    output busy, done, red_pos, blue_pos, red_count, blue_count,
           winner, board_full
  );

endinterface
`default_nettype wire

// File: rtl/board_state_scanner_line_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : line_mask_gen
// Description : Combinational map from a line index to the set of tiles on
//               that line. Lines 0..SIDE-1 are rows, SIDE..2*SIDE-1 columns,
//               2*SIDE the main diagonal, 2*SIDE+1 the anti-diagonal.
//               i_line : line index
//               o_mask : bit i set when tile i lies on the line
// Revision    : 1.0 - initial release
// ============================================================================
module line_mask_gen #(
  parameter int SIDE  = 3,
  parameter int TILES = SIDE * SIDE,
  parameter int LINES = 2 * SIDE + 2,
  parameter int LW    = $clog2(LINES)
) (
  input  wire logic [LW-1:0]    i_line,
  output logic      [TILES-1:0] o_mask
);

  // Row/column of every tile are elaboration-time constants, so each mask bit
  // reduces to a handful of comparisons against fixed line numbers.
  for (genvar i = 0; i < TILES; i++) begin : g_tile
    localparam int ROW = i / SIDE;
    localparam int COL = i % SIDE;
    localparam bit ON_DIAG = (ROW == COL);
    localparam bit ON_ANTI = (COL == SIDE - 1 - ROW);

    logic w_row_hit;
    logic w_col_hit;
    logic w_diag_hit;
    logic w_anti_hit;

    assign w_row_hit  = (i_line == LW'(ROW));
    assign w_col_hit  = (i_line == LW'(SIDE + COL));
    assign w_diag_hit = ON_DIAG && (i_line == LW'(2 * SIDE));
    assign w_anti_hit = ON_ANTI && (i_line == LW'(2 * SIDE + 1));
    assign o_mask[i]  = w_row_hit | w_col_hit | w_diag_hit | w_anti_hit;
  end

endmodule
`default_nettype wire

// File: rtl/board_state_scanner.sv
`default_nettype none
// ============================================================================
// Module      : board_state_scanner
// Description : Sequential board decoder. On start it snapshots the packed
//               board, decodes one tile per cycle into red/blue masks and
//               counts, then tests one full line per cycle for a win.
//               Results appear on registered outputs with a one-cycle done.
//               clk   : rising-edge clock
//               reset : synchronous active-low reset
//               bus   : slave side of board_state_scanner_if
// Revision    : 1.0 - initial release
// ============================================================================
module board_state_scanner
  import board_pkg::*;
#(
  parameter int SIDE = 3,
  parameter int CW   = $clog2(SIDE*SIDE+1)
) (
  input  wire logic               clk,
  input  wire logic               reset,
  board_state_scanner_if.slave    bus
);

  localparam int TILES = SIDE * SIDE;
  localparam int LINES = 2 * SIDE + 2;
  localparam int KW    = $clog2(TILES);
  localparam int LW    = $clog2(LINES);

  localparam logic [KW-1:0] LAST_TILE = KW'(TILES - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

  // Control and working state
  state_t               state_q,     state_d;
  logic [2*TILES-1:0]   snap_q,      snap_d;
  logic [KW-1:0]        k_q,         k_d;
  logic [LW-1:0]        l_q,         l_d;
  logic [TILES-1:0]     red_mask_q,  red_mask_d;
  logic [TILES-1:0]     blue_mask_q, blue_mask_d;
  logic [CW-1:0]        red_cnt_q,   red_cnt_d;
  logic [CW-1:0]        blue_cnt_q,  blue_cnt_d;
  logic                 red_win_q,   red_win_d;
  logic                 blue_win_q,  blue_win_d;

  // Visible outputs
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic [TILES-1:0]     red_pos_q,   red_pos_d;
  logic [TILES-1:0]     blue_pos_q,  blue_pos_d;
  logic [CW-1:0]        red_out_q,   red_out_d;
  logic [CW-1:0]        blue_out_q,  blue_out_d;
  logic [1:0]           winner_q,    winner_d;
  logic                 full_q,      full_d;

  logic [1:0]           tile;
  logic [TILES-1:0]     line_mask;
  logic [CW:0]          total_cnt;

  line_mask_gen #(
    .SIDE (SIDE)
  ) u_line_mask_gen (
    .i_line (l_q),
    .o_mask (line_mask)
  );

  // Select the current tile's two-bit field from the snapshot.
  always_comb begin
    tile = 2'b00;
    for (int i = 0; i < TILES; i++) begin
      if (k_q == KW'(i)) begin
        tile = snap_q[2*i +: 2];
      end
    end
  end

  // One extra bit so the sum of two CW-wide counts cannot wrap.
  assign total_cnt = {1'b0, red_cnt_q} + {1'b0, blue_cnt_q};

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    k_d         = k_q;
    l_d         = l_q;
    red_mask_d  = red_mask_q;
    blue_mask_d = blue_mask_q;
    red_cnt_d   = red_cnt_q;
    blue_cnt_d  = blue_cnt_q;
    red_win_d   = red_win_q;
    blue_win_d  = blue_win_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    red_pos_d   = red_pos_q;
    blue_pos_d  = blue_pos_q;
    red_out_d   = red_out_q;
    blue_out_d  = blue_out_q;
    winner_d    = winner_q;
    full_d      = full_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d      = bus.board_in;
          k_d         = '0;
          l_d         = '0;
          red_mask_d  = '0;
          blue_mask_d = '0;
          red_cnt_d   = '0;
          blue_cnt_d  = '0;
          red_win_d   = 1'b0;
          blue_win_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        // An empty tile ignores its colour bit entirely.
        if (tile[OCC_BIT]) begin
          if (tile[COLOR_BIT] == COLOR_RED) begin
            red_mask_d[k_q] = 1'b1;
            red_cnt_d       = red_cnt_q + CW'(1);
          end else begin
            blue_mask_d[k_q] = 1'b1;
            blue_cnt_d       = blue_cnt_q + CW'(1);
          end
        end
        if (k_q == LAST_TILE) begin
          state_d = CHECK;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      CHECK: begin
        if ((line_mask & red_mask_q) == line_mask) begin
          red_win_d = 1'b1;
        end
        if ((line_mask & blue_mask_q) == line_mask) begin
          blue_win_d = 1'b1;
        end
        if (l_q == LAST_LINE) begin
          state_d = DONE;
        end else begin
          l_d = l_q + LW'(1);
        end
      end

      DONE: begin
        red_pos_d  = red_mask_q;
        blue_pos_d = blue_mask_q;
        red_out_d  = red_cnt_q;
        blue_out_d = blue_cnt_q;
        full_d     = (total_cnt == (CW+1)'(TILES));
        unique case ({red_win_q, blue_win_q})
          2'b11:   winner_d = WIN_BOTH;
          2'b10:   winner_d = WIN_RED;
          2'b01:   winner_d = WIN_BLUE;
          default: winner_d = WIN_NONE;
        endcase
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      k_q         <= '0;
      l_q         <= '0;
      red_mask_q  <= '0;
      blue_mask_q <= '0;
      red_cnt_q   <= '0;
      blue_cnt_q  <= '0;
      red_win_q   <= 1'b0;
      blue_win_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      red_pos_q   <= '0;
      blue_pos_q  <= '0;
      red_out_q   <= '0;
      blue_out_q  <= '0;
      winner_q    <= WIN_NONE;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      k_q         <= k_d;
      l_q         <= l_d;
      red_mask_q  <= red_mask_d;
      blue_mask_q <= blue_mask_d;
      red_cnt_q   <= red_cnt_d;
      blue_cnt_q  <= blue_cnt_d;
      red_win_q   <= red_win_d;
      blue_win_q  <= blue_win_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      red_pos_q   <= red_pos_d;
      blue_pos_q  <= blue_pos_d;
      red_out_q   <= red_out_d;
      blue_out_q  <= blue_out_d;
      winner_q    <= winner_d;
      full_q      <= full_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.red_pos    = red_pos_q;
  assign bus.blue_pos   = blue_pos_q;
  assign bus.red_count  = red_out_q;
  assign bus.blue_count = blue_out_q;
  assign bus.winner     = winner_q;
  assign bus.board_full = full_q;

endmodule
`default_nettype wire

// File: tb/tb_board_state_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_state_scanner
// Description : Self-checking bench for board_state_scanner (SIDE=3). A
//               cycle-level reference model predicts busy/done/results and is
//               compared every cycle; directed scans pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_state_scanner;

  localparam int SIDE  = 3;
  localparam int TILES = SIDE * SIDE;
  localparam int LINES = 2 * SIDE + 2;
  localparam int CW    = $clog2(TILES + 1);
  localparam int LAT   = TILES + LINES + 2;  // negedges from start drive to done

  typedef struct packed {
    logic [TILES-1:0] rp;
    logic [TILES-1:0] bp;
    logic [CW-1:0]    rc;
    logic [CW-1:0]    bc;
    logic [1:0]       win;
    logic             full;
  } res_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;

  board_state_scanner_if #(.SIDE(SIDE)) bus ();

  board_state_scanner #(.SIDE(SIDE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile j (0..SIDE-1) along line L, from the row/column/diagonal geometry.
  function automatic int line_tile(input int l, input int j);
    if (l < SIDE)           return l * SIDE + j;
    else if (l < 2 * SIDE)  return j * SIDE + (l - SIDE);
    else if (l == 2 * SIDE) return j * SIDE + j;
    else                    return j * SIDE + (SIDE - 1 - j);
  endfunction

  function automatic res_t score(input logic [2*TILES-1:0] b);
    res_t r;
    int   nr, nb;
    bit   rw, bw;
    r  = '0;
    nr = 0;
    nb = 0;
    for (int i = 0; i < TILES; i++) begin
      if (b[2*i+1]) begin
        if (b[2*i]) begin r.rp[i] = 1'b1; nr++; end
        else        begin r.bp[i] = 1'b1; nb++; end
      end
    end
    rw = 0;
    bw = 0;
    for (int l = 0; l < LINES; l++) begin
      bit all_r, all_b;
      all_r = 1;
      all_b = 1;
      for (int j = 0; j < SIDE; j++) begin
        if (!r.rp[line_tile(l, j)]) all_r = 0;
        if (!r.bp[line_tile(l, j)]) all_b = 0;
      end
      if (all_r) rw = 1;
      if (all_b) bw = 1;
    end
    r.rc   = CW'(nr);
    r.bc   = CW'(nb);
    r.win  = {rw, bw};
    r.full = (nr + nb == TILES);
    return r;
  endfunction

  // Reference model: a scan accepted at an edge finishes TILES+LINES+1 edges
  // later; the model is idle again on the edge after that.
  bit   m_active, m_busy, m_done;
  int   m_cnt;
  res_t m_vis, m_pend;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      m_vis = '0; m_pend = '0;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == TILES + LINES + 1) begin
        m_active = 0; m_busy = 0; m_done = 1; m_vis = m_pend;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
        m_active = 1; m_busy = 1; m_cnt = 0;
        m_pend = score(bus.board_in);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       32'(bus.busy),       32'(m_busy));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("red_pos",    32'(bus.red_pos),    32'(m_vis.rp));
      chk("blue_pos",   32'(bus.blue_pos),   32'(m_vis.bp));
      chk("red_count",  32'(bus.red_count),  32'(m_vis.rc));
      chk("blue_count", 32'(bus.blue_count), 32'(m_vis.bc));
      chk("winner",     32'(bus.winner),     32'(m_vis.win));
      chk("board_full", 32'(bus.board_full), 32'(m_vis.full));
    end
  end

  // Wait for done, bounded; returns negedges counted since the start drive.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic scan(input logic [17:0] b, input string tag, input logic [8:0] erp,
                      input logic [8:0] ebp, input int erc, input int ebc,
                      input logic [1:0] ewin, input logic efull);
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.board_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk({tag, "_latency"}, 32'(n),              32'(LAT));
    chk({tag, "_rp"},      32'(bus.red_pos),    32'(erp));
    chk({tag, "_bp"},      32'(bus.blue_pos),   32'(ebp));
    chk({tag, "_rc"},      32'(bus.red_count),  32'(erc));
    chk({tag, "_bc"},      32'(bus.blue_count), 32'(ebc));
    chk({tag, "_win"},     32'(bus.winner),     32'(ewin));
    chk({tag, "_full"},    32'(bus.board_full), 32'(efull));
  endtask

  initial begin
    int n, dones;
    checks = 0;
    errors = 0;
    chk_en = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.board_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_busy",   32'(bus.busy),    32'd0);
    chk("rst_winner", 32'(bus.winner),  32'd0);
    chk("rst_rp",     32'(bus.red_pos), 32'd0);
    reset = 1'b1;

    scan(18'h0003F, "row0_red",  9'h007, 9'h000, 3, 0, 2'b10, 1'b0);
    scan(18'h02082, "col0_blue", 9'h000, 9'h049, 0, 3, 2'b01, 1'b0);
    scan(18'h15555, "empty",     9'h000, 9'h000, 0, 0, 2'b00, 1'b0);
    scan(18'h3EAFB, "draw",      9'h18D, 9'h072, 5, 4, 2'b00, 1'b1);
    scan(18'h20202, "diag_blue", 9'h000, 9'h111, 0, 3, 2'b01, 1'b0);
    scan(18'h03330, "anti_red",  9'h054, 9'h000, 3, 0, 2'b10, 1'b0);
    scan(18'h2A03F, "both",      9'h007, 9'h1C0, 3, 3, 2'b11, 1'b0);

    // Second start mid-scan and board changes are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.board_in = 18'h0003F;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    chk("mid_old_win", 32'(bus.winner), 32'(2'b11));
    bus.start = 1'b1;
    bus.board_in = 18'h02082;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    bus.board_in = 18'h3FFFF;
    dones = 0;
    while (!bus.done && n < 60) begin @(negedge clk); n++; end
    chk("mid_latency", 32'(n),            32'(LAT));
    chk("mid_rp",      32'(bus.red_pos),  32'h007);
    chk("mid_win",     32'(bus.winner),   32'(2'b10));
    repeat (25) begin @(negedge clk); if (bus.done) dones++; end
    chk("mid_no_extra_done", 32'(dones), 32'd0);

    // Start held high: back-to-back scans, cadence checked by the model.
    bus.board_in = 18'h03330;
    bus.start = 1'b1;
    repeat (45) @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("held_win", 32'(bus.winner), 32'(2'b10));

    // Reset mid-scan clears everything and no done follows.
    bus.board_in = 18'h02082;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rr_busy", 32'(bus.busy),       32'd0);
    chk("rr_done", 32'(bus.done),       32'd0);
    chk("rr_rp",   32'(bus.red_pos),    32'd0);
    chk("rr_rc",   32'(bus.red_count),  32'd0);
    chk("rr_win",  32'(bus.winner),     32'd0);
    dones = 0;
    repeat (30) begin @(negedge clk); if (bus.done) dones++; end
    chk("rr_no_done", 32'(dones), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
